// File: rtl/approx_err_monitor.sv
// approx_err_monitor: per-lane approx-vs-exact error statistics over a run.
// Ports: start/clear/sample_target ctrl, in_valid/in_ready beats, chan_sel -> stat_*, busy/done.
module approx_err_monitor #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 2,
  parameter int ERR_W    = 16,
  parameter int CNT_W    = 32,
  parameter int SEL_W    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          clear,
  input  logic [CNT_W-1:0]              sample_target,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*WIDTH-1:0]     approx_data,
  input  logic [CHANNELS*WIDTH-1:0]     exact_data,
  input  logic [SEL_W-1:0]              chan_sel,
  output logic signed [ERR_W+CNT_W-1:0] stat_sum,
  output logic [2*ERR_W+CNT_W-1:0]      stat_sqsum,
  output logic [ERR_W-1:0]              stat_maxabs,
  output logic [CNT_W-1:0]              stat_nonzero,
  output logic [CNT_W-1:0]              stat_sat,
  output logic [CNT_W-1:0]              sample_count,
  output logic                          busy,
  output logic                          done
);

  localparam int SUM_W = ERR_W + CNT_W;
  localparam int SQ_W  = 2 * ERR_W + CNT_W;
  localparam int HI_W  = WIDTH - ERR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] target, cnt, cnt_nxt;
  logic             accept, start_run, wipe, s1_valid;

  logic [WIDTH-1:0]   diff    [CHANNELS];
  logic [HI_W-1:0]    hi      [CHANNELS];
  logic [ERR_W-1:0]   e_nxt   [CHANNELS];
  logic               sat_nxt [CHANNELS];
  logic [ERR_W-1:0]   s1_err  [CHANNELS];
  logic               s1_sat  [CHANNELS];
  logic [ERR_W-1:0]   s1_abs  [CHANNELS];
  logic [2*ERR_W-1:0] s1_sq   [CHANNELS];

  logic [SUM_W-1:0] acc_sum [CHANNELS];
  logic [SQ_W-1:0]  acc_sq  [CHANNELS];
  logic [ERR_W-1:0] acc_max [CHANNELS];
  logic [CNT_W-1:0] acc_nz  [CHANNELS];
  logic [CNT_W-1:0] acc_sat [CHANNELS];

  assign in_ready     = (state == RUN) && (cnt < target);
  assign accept       = in_valid && in_ready;
  assign cnt_nxt      = cnt + CNT_W'(accept);
  assign start_run    = start && ((state == IDLE) || (state == DONE));
  assign wipe         = clear || start_run;
  assign busy         = (state == RUN) || (state == DRAIN);
  assign done         = (state == DONE);
  assign sample_count = cnt;

  // The wrapped difference fits ERR_W signed only when every bit from
  // ERR_W-1 upward equals the sign bit.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      diff[k]    = approx_data[k*WIDTH +: WIDTH]
                 - exact_data[k*WIDTH +: WIDTH];
      hi[k]      = diff[k][WIDTH-1:ERR_W-1];
      sat_nxt[k] = !((&hi[k]) || !(|hi[k]));
      if (sat_nxt[k])
        e_nxt[k] = diff[k][WIDTH-1] ? {1'b1, {(ERR_W-1){1'b0}}}
                                    : {1'b0, {(ERR_W-1){1'b1}}};
      else
        e_nxt[k] = diff[k][ERR_W-1:0];
      s1_abs[k] = s1_err[k][ERR_W-1] ? (~s1_err[k] + ERR_W'(1))
                                     : s1_err[k];
      s1_sq[k]  = {{ERR_W{1'b0}}, s1_abs[k]}
                * {{ERR_W{1'b0}}, s1_abs[k]};
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (cnt_nxt >= target) state_nxt = DRAIN;
      DRAIN:      if (!s1_valid && !accept) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      target   <= '0;
      cnt      <= '0;
      s1_valid <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        s1_err[k]  <= '0;
        s1_sat[k]  <= 1'b0;
        acc_sum[k] <= '0;
        acc_sq[k]  <= '0;
        acc_max[k] <= '0;
        acc_nz[k]  <= '0;
        acc_sat[k] <= '0;
      end
    end else begin
      state    <= state_nxt;
      s1_valid <= accept && !wipe;
      cnt      <= wipe ? '0 : cnt_nxt;
      if (clear)          target <= '0;
      else if (start_run) target <= sample_target;
      for (int k = 0; k < CHANNELS; k++) begin
        if (accept) begin
          s1_err[k] <= e_nxt[k];
          s1_sat[k] <= sat_nxt[k];
        end
        if (wipe) begin
          acc_sum[k] <= '0;
          acc_sq[k]  <= '0;
          acc_max[k] <= '0;
          acc_nz[k]  <= '0;
          acc_sat[k] <= '0;
        end else if (s1_valid) begin
          acc_sum[k] <= acc_sum[k]
                      + {{CNT_W{s1_err[k][ERR_W-1]}}, s1_err[k]};
          acc_sq[k]  <= acc_sq[k] + {{CNT_W{1'b0}}, s1_sq[k]};
          if (s1_abs[k] > acc_max[k]) acc_max[k] <= s1_abs[k];
          acc_nz[k]  <= acc_nz[k] + CNT_W'(s1_err[k] != '0);
          acc_sat[k] <= acc_sat[k] + CNT_W'(s1_sat[k]);
        end
      end
    end
  end

  // Out-of-range selects match no lane and read back as zero.
  always_comb begin
    stat_sum     = '0;
    stat_sqsum   = '0;
    stat_maxabs  = '0;
    stat_nonzero = '0;
    stat_sat     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (chan_sel == SEL_W'(k)) begin
        stat_sum     = acc_sum[k];
        stat_sqsum   = acc_sq[k];
        stat_maxabs  = acc_max[k];
        stat_nonzero = acc_nz[k];
        stat_sat     = acc_sat[k];
      end
    end
  end

endmodule

// File: tb/tb_approx_err_monitor.sv
// tb_approx_err_monitor: directed bench for approx_err_monitor.
// Run-level model of the statistics plus literal spot checks.
module tb_approx_err_monitor;

  localparam int WIDTH = 64;
  localparam int CH    = 2;
  localparam int ERR_W = 16;
  localparam int CNT_W = 32;
  localparam int SEL_W = 1;
  localparam longint NEVER = 64'h7fff_ffff_ffff_ffff;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic                    clear = 1'b0;
  logic [CNT_W-1:0]        sample_target = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [CH*WIDTH-1:0]     approx_data = '0;
  logic [CH*WIDTH-1:0]     exact_data = '0;
  logic [SEL_W-1:0]        chan_sel = '0;
  logic signed [47:0]      stat_sum;
  logic [63:0]             stat_sqsum;
  logic [15:0]             stat_maxabs;
  logic [31:0]             stat_nonzero;
  logic [31:0]             stat_sat;
  logic [31:0]             sample_count;
  logic                    busy;
  logic                    done;

  approx_err_monitor #(
    .WIDTH(WIDTH), .CHANNELS(CH), .ERR_W(ERR_W),
    .CNT_W(CNT_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .sample_target(sample_target), .in_valid(in_valid),
    .in_ready(in_ready), .approx_data(approx_data),
    .exact_data(exact_data), .chan_sel(chan_sel),
    .stat_sum(stat_sum), .stat_sqsum(stat_sqsum),
    .stat_maxabs(stat_maxabs), .stat_nonzero(stat_nonzero),
    .stat_sat(stat_sat), .sample_count(sample_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [47:0] v);
    return {{16{v[47]}}, v};
  endfunction

  // ---------------- run-level model ----------------
  longint cyc = 0;
  longint done_edge = NEVER;
  bit     active = 1'b0;
  longint m_cnt = 0, m_tgt = 0;
  longint m_sum [CH];
  longint m_sq  [CH];
  longint m_max [CH];
  longint m_nz  [CH];
  longint m_sat [CH];
  bit     pend = 1'b0;
  longint pe [CH];
  bit     ps [CH];

  function automatic void sat_err(input logic [63:0] a, input logic [63:0] x,
                                  output longint e, output bit s);
    longint d;
    d = a - x;
    s = 1'b1;
    if (d > 32767) e = 32767;
    else if (d < -32768) e = -32768;
    else begin
      e = d;
      s = 1'b0;
    end
  endfunction

  function automatic void m_zero();
    for (int k = 0; k < CH; k++) begin
      m_sum[k] = 0; m_sq[k] = 0; m_max[k] = 0;
      m_nz[k] = 0; m_sat[k] = 0;
    end
  endfunction

  initial m_zero();

  always @(posedge clk or negedge rst_n) begin
    bit acc;
    longint a;
    if (!rst_n) begin
      m_zero();
      active = 1'b0; m_cnt = 0; m_tgt = 0;
      done_edge = NEVER; pend = 1'b0;
    end else begin
      cyc++;
      acc = active && in_valid && (m_cnt < m_tgt);
      if (pend) begin
        for (int k = 0; k < CH; k++) begin
          a = (pe[k] < 0) ? -pe[k] : pe[k];
          m_sum[k] += pe[k];
          m_sq[k]  += a * a;
          if (a > m_max[k]) m_max[k] = a;
          if (pe[k] != 0) m_nz[k]++;
          if (ps[k]) m_sat[k]++;
        end
        pend = 1'b0;
      end
      if (clear) begin
        m_zero();
        active = 1'b0; m_cnt = 0; m_tgt = 0; done_edge = NEVER;
      end else if (start && (!active || (cyc - 1) >= done_edge)) begin
        m_zero();
        active = 1'b1; m_cnt = 0; m_tgt = sample_target;
        done_edge = (m_tgt == 0) ? cyc + 2 : NEVER;
      end else if (acc) begin
        m_cnt++;
        for (int k = 0; k < CH; k++)
          sat_err(approx_data[k*WIDTH +: WIDTH],
                  exact_data[k*WIDTH +: WIDTH], pe[k], ps[k]);
        pend = 1'b1;
        if (m_cnt == m_tgt) done_edge = cyc + 2;
      end
    end
  end

  always @(negedge clk) begin
    bit dn;
    int s;
    dn = active && (cyc >= done_edge);
    s  = int'(chan_sel);
    chk("in_ready", 64'(in_ready), 64'(active && (m_cnt < m_tgt)));
    chk("busy", 64'(busy), 64'(active && !dn));
    chk("done", 64'(done), 64'(dn));
    chk("sample_count", 64'(sample_count), m_cnt);
    chk("sum", sx(stat_sum), m_sum[s]);
    chk("sqsum", stat_sqsum, m_sq[s]);
    chk("maxabs", 64'(stat_maxabs), m_max[s]);
    chk("nonzero", 64'(stat_nonzero), m_nz[s]);
    chk("sat", 64'(stat_sat), m_sat[s]);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic [63:0] a,
                          input logic [63:0] x);
    approx_data[k*WIDTH +: WIDTH] = a;
    exact_data[k*WIDTH +: WIDTH]  = x;
  endtask

  task automatic go(input logic [31:0] t);
    start = 1'b1;
    sample_target = t;
    step();
    start = 1'b0;
  endtask

  int e1 [4] = '{3, -5, 0, 2};
  bit v4 [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(sample_count), 64'd0);
    chk("rst_sum", sx(stat_sum), 64'd0);
    rst_n = 1'b1;
    step();

    // 1: four beats on lane0, lane1 exact
    chan_sel = '0;
    go(32'd4);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_lane(0, 64'(100 + e1[i]), 64'd100);
      set_lane(1, 64'(777 + i), 64'(777 + i));
      chan_sel = SEL_W'(i % 2);
      step();
    end
    chk("t1_ready_low", 64'(in_ready), 64'd0);
    chk("t1_count", 64'(sample_count), 64'd4);
    chk("t1_done_e0", 64'(done), 64'd0);
    step();
    chk("t1_done_e1", 64'(done), 64'd0);
    step();
    chk("t1_done_e2", 64'(done), 64'd1);
    in_valid = 1'b0;
    chan_sel = 1'b0;
    #1;
    chk("t1_l0_sum", sx(stat_sum), 64'd0);
    chk("t1_l0_sq", stat_sqsum, 64'd38);
    chk("t1_l0_max", 64'(stat_maxabs), 64'd5);
    chk("t1_l0_nz", 64'(stat_nonzero), 64'd3);
    chk("t1_l0_sat", 64'(stat_sat), 64'd0);
    chan_sel = 1'b1;
    #1;
    chk("t1_l1_sq", stat_sqsum, 64'd0);
    chk("t1_l1_nz", 64'(stat_nonzero), 64'd0);
    step();

    // 2: negative saturation on lane0
    go(32'd1);
    set_lane(0, 64'd0, 64'd1000000);
    set_lane(1, 64'd5, 64'd5);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chan_sel = 1'b0;
    #1;
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_sum", sx(stat_sum), 64'hffff_ffff_ffff_8000);
    chk("t2_max", 64'(stat_maxabs), 64'd32768);
    chk("t2_sat", 64'(stat_sat), 64'd1);
    chk("t2_sq", stat_sqsum, 64'd1073741824);

    // 3: difference wraps to +1 on lane1
    go(32'd1);
    set_lane(0, 64'd9, 64'd9);
    set_lane(1, 64'd0, 64'hffff_ffff_ffff_ffff);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chan_sel = 1'b1;
    #1;
    chk("t3_sum", sx(stat_sum), 64'd1);
    chk("t3_sq", stat_sqsum, 64'd1);
    chk("t3_sat", 64'(stat_sat), 64'd0);

    // 4: gapped valid; sixth beat arrives after target reached
    chan_sel = 1'b0;
    go(32'd3);
    for (int i = 0; i < 6; i++) begin
      in_valid = v4[i];
      set_lane(0, 64'(i + 1), 64'd0);
      set_lane(1, 64'd0, 64'd0);
      step();
    end
    in_valid = 1'b0;
    chk("t4_count", 64'(sample_count), 64'd3);
    step();
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_sum", sx(stat_sum), 64'd9);
    chk("t4_sq", stat_sqsum, 64'd35);
    chk("t4_nz", 64'(stat_nonzero), 64'd3);

    // 5: clear mid-run, then start+clear together
    go(32'd10);
    in_valid = 1'b1;
    set_lane(0, 64'd50, 64'd0);
    step();
    step();
    in_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_count", 64'(sample_count), 64'd0);
    chk("t5_sum", sx(stat_sum), 64'd0);
    step();
    chk("t5_sum_late", sx(stat_sum), 64'd0);
    start = 1'b1;
    clear = 1'b1;
    step();
    start = 1'b0;
    clear = 1'b0;
    chk("t5_sc_busy", 64'(busy), 64'd0);
    step();
    chk("t5_sc_busy2", 64'(busy), 64'd0);

    // 6: zero-length run, then async reset mid-run
    go(32'd0);
    begin
      int n;
      n = 1;
      while (!done && n < 3) begin
        step();
        n++;
      end
      chk("t6_done_in3", 64'(done), 64'd1);
    end
    chk("t6_count", 64'(sample_count), 64'd0);
    chk("t6_sq", stat_sqsum, 64'd0);
    go(32'd5);
    in_valid = 1'b1;
    set_lane(0, 64'd10, 64'd0);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_ready", 64'(in_ready), 64'd0);
    chk("t6_rst_count", 64'(sample_count), 64'd0);
    chk("t6_rst_sum", sx(stat_sum), 64'd0);
    chk("t6_rst_sq", stat_sqsum, 64'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
